// File: rtl/regfile_dump.sv
// Streams a contiguous range of register-file entries through a spare read port
// as (index, value) words on a valid/ready interface, one read per READ cycle.
module regfile_dump #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int IW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [IW-1:0]   first_idx,
  input  logic [IW-1:0]   last_idx,
  input  logic            abort,
  output logic [IW-1:0]   rf_addr,
  input  logic [XLEN-1:0] rf_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [IW-1:0]   out_index,
  output logic            out_last,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [IW-1:0]   index;
    logic            last;
  } word_t;

  state_t        state, state_nxt;
  logic [IW-1:0] cur, last_ptr;
  word_t         word;
  logic          vld, done_q, err_q;
  logic          accept, illegal, hs;

  assign accept  = (state == IDLE) && start && (first_idx <= last_idx);
  assign illegal = (state == IDLE) && start && (first_idx >  last_idx);
  assign hs      = vld && out_ready;

  // abort wins over a handshake in the same cycle
  always_comb begin
    state_nxt = state;
    rf_addr   = '0;
    busy      = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = READ;
      READ: begin
        rf_addr   = cur;
        busy      = 1'b1;
        state_nxt = abort ? DONE : SEND;
      end
      SEND: begin
        rf_addr = cur;
        busy    = 1'b1;
        if (abort)   state_nxt = DONE;
        else if (hs) state_nxt = word.last ? DONE : READ;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur      <= '0;
      last_ptr <= '0;
      word     <= '0;
      vld      <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      // done/err are registered so an illegal range reports one cycle later
      done_q <= illegal || (state_nxt == DONE);
      err_q  <= illegal;
      case (state)
        IDLE: if (accept) begin
          cur      <= first_idx;
          last_ptr <= last_idx;
        end
        READ: if (!abort) begin
          word.data  <= rf_data;
          word.index <= cur;
          word.last  <= (cur == last_ptr);
          vld        <= 1'b1;
        end
        SEND: if (abort || hs) begin
          vld <= 1'b0;
          // cur stops at the last index, so a range ending at NREGS-1 never wraps
          if (!abort && !word.last) cur <= cur + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = vld;
  assign out_data  = word.data;
  assign out_index = word.index;
  assign out_last  = word.last;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: expected words queued at start, popped on handshake.
module tb_regfile_dump;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start, abort, out_ready;
  logic [4:0]      first_idx, last_idx, rf_addr, out_index;
  logic [XLEN-1:0] rf_data, out_data;
  logic            out_valid, out_last, busy, done, err;

  regfile_dump #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_idx(first_idx), .last_idx(last_idx),
    .abort(abort), .rf_addr(rf_addr), .rf_data(rf_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [XLEN-1:0] rf   [NREGS];
  logic [XLEN-1:0] gold [NREGS];
  assign rf_data = rf[rf_addr];

  typedef struct packed {
    logic [4:0]      idx;
    logic [XLEN-1:0] data;
    logic            last;
  } word_t;

  word_t exp_q[$];
  int checks = 0, failures = 0;
  int words_seen = 0, done_seen = 0, err_seen = 0, ed_seen = 0, valid_seen = 0;
  int ncyc = 0, start_cyc = 0, done_cyc = 0, first_v_cyc = 0;
  bit v_armed = 0, stalled = 0;
  word_t held;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rf_addr"},   rf_addr,   0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"},  out_data,  0);
    chk({tag, "_out_index"}, out_index, 0);
    chk({tag, "_out_last"},  out_last,  0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_done"},      done,      0);
    chk({tag, "_err"},       err,       0);
  endtask

  task automatic do_start(input int f, input int l);
    word_t w;
    if (f <= l)
      for (int i = f; i <= l; i++) begin
        w.idx = 5'(i); w.data = gold[i]; w.last = (i == l);
        exp_q.push_back(w);
      end
    first_idx = 5'(f); last_idx = 5'(l); start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = done_seen;
    int n = 0;
    while (done_seen == d0 && n < budget) begin tick(1); n++; end
    if (done_seen == d0) chk({tag, "_done_timeout"}, 0, 1);
  endtask

  // output monitor / scoreboard
  always @(negedge clk) begin
    word_t e;
    ncyc++;
    if (done) begin done_seen++; done_cyc = ncyc; end
    if (err) err_seen++;
    if (err && done) ed_seen++;
    if (out_valid) valid_seen++;
    if (out_valid && v_armed) begin first_v_cyc = ncyc; v_armed = 0; end
    if (start) begin start_cyc = ncyc; v_armed = 1; end
    if (out_valid && stalled) begin
      chk("stall_data",  out_data,  held.data);
      chk("stall_index", out_index, held.idx);
      chk("stall_last",  out_last,  held.last);
    end
    if (out_valid && out_ready && !abort) begin
      words_seen++;
      if (exp_q.size() == 0) chk("sb_unexpected_word", {27'd0, out_index}, 64'hFFFF);
      else begin
        e = exp_q.pop_front();
        chk("sb_index", out_index, e.idx);
        chk("sb_data",  out_data,  e.data);
        chk("sb_last",  out_last,  e.last);
      end
    end
    stalled   = out_valid && !out_ready;
    held.data = out_data; held.idx = out_index; held.last = out_last;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, e0, v0, ed0, n, stall;
    bit found;
    start = 0; abort = 0; out_ready = 0; first_idx = 0; last_idx = 0;
    for (int i = 0; i < NREGS; i++) rf[i] = (i == 0) ? '0 : 32'h1000_0000 + i;
    rf[5] = 32'hDEAD_BEEF;
    for (int i = 0; i < NREGS; i++) gold[i] = rf[i];

    #1 rst_n = 0;
    #2 chk_zero("reset");
    tick(2); rst_n = 1; tick(1);

    // full dump 0..31
    out_ready = 1; w0 = words_seen; d0 = done_seen; e0 = err_seen;
    do_start(0, 31);
    wait_done("full", 200);
    chk("full_words", words_seen - w0, 32);
    chk("full_queue", exp_q.size(), 0);
    chk("full_latency", first_v_cyc - start_cyc, 2);
    chk("full_cycles", done_cyc - start_cyc, 65);
    tick(2);
    chk("full_done_pulses", done_seen - d0, 1);
    chk("full_err", err_seen - e0, 0);
    chk("full_busy_after", busy, 0);

    // backpressure 3..5, 4 stall cycles per word, stray start while busy
    out_ready = 0; w0 = words_seen; d0 = done_seen;
    do_start(3, 5);
    stall = 0; n = 0;
    while (done_seen == d0 && n < 300) begin
      if (n == 3) begin start = 1; first_idx = 0; last_idx = 0; end
      else start = 0;
      if (out_valid && stall < 4) begin out_ready = 0; stall++; end
      else if (out_valid) out_ready = 1;
      else begin out_ready = 0; stall = 0; end
      tick(1); n++;
    end
    start = 0;
    if (done_seen == d0) chk("bp_done_timeout", 0, 1);
    chk("bp_words", words_seen - w0, 3);
    chk("bp_queue", exp_q.size(), 0);
    tick(2);
    chk("bp_no_extra_words", words_seen - w0, 3);

    // single-word range
    out_ready = 1; w0 = words_seen;
    do_start(7, 7);
    wait_done("single", 50);
    chk("single_words", words_seen - w0, 1);
    chk("single_queue", exp_q.size(), 0);

    // illegal range
    v0 = valid_seen; e0 = err_seen; d0 = done_seen; ed0 = ed_seen;
    do_start(9, 2);
    tick(3);
    chk("illegal_err", err_seen - e0, 1);
    chk("illegal_done", done_seen - d0, 1);
    chk("illegal_err_with_done", ed_seen - ed0, 1);
    chk("illegal_no_valid", valid_seen - v0, 0);

    // abort during SEND of index 4 with out_ready high
    out_ready = 1; w0 = words_seen; d0 = done_seen; e0 = err_seen;
    do_start(0, 31);
    found = 0; n = 0;
    while (!found && n < 100) begin
      if (out_valid && out_index == 5'd4) found = 1;
      else begin tick(1); n++; end
    end
    chk("abort_reached_idx4", found, 1);
    abort = 1; tick(1); abort = 0;
    chk("abort_valid_next", out_valid, 0);
    tick(2);
    chk("abort_words", words_seen - w0, 4);
    chk("abort_done", done_seen - d0, 1);
    chk("abort_err", err_seen - e0, 0);
    chk("abort_busy", busy, 0);
    exp_q.delete();
    w0 = words_seen;
    do_start(2, 3);
    wait_done("post_abort", 50);
    chk("post_abort_words", words_seen - w0, 2);
    chk("post_abort_queue", exp_q.size(), 0);

    // async reset during READ of index 10
    do_start(0, 31);
    found = 0; n = 0;
    while (!found && n < 100) begin
      if (busy && !out_valid && rf_addr == 5'd10) found = 1;
      else begin tick(1); n++; end
    end
    chk("rst_reached_read10", found, 1);
    d0 = done_seen;
    #2 rst_n = 0;
    #1 chk_zero("midreset");
    tick(2); rst_n = 1; tick(1);
    chk("midreset_no_done", done_seen - d0, 0);
    exp_q.delete();
    w0 = words_seen;
    do_start(0, 1);
    wait_done("post_reset", 50);
    chk("post_reset_words", words_seen - w0, 2);
    chk("post_reset_queue", exp_q.size(), 0);

    // snapshot: x6 written during SEND of index 5
    gold[6] = 32'hCAFE_F00D; w0 = words_seen;
    do_start(4, 7);
    found = 0; n = 0;
    while (!found && n < 100) begin
      if (out_valid && out_index == 5'd5) found = 1;
      else begin tick(1); n++; end
    end
    chk("snap_reached_idx5", found, 1);
    rf[6] = 32'hCAFE_F00D;
    wait_done("snap", 50);
    chk("snap_words", words_seen - w0, 4);
    chk("snap_queue", exp_q.size(), 0);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
Sequencer that reads a contiguous range of architectural registers through a spare register-file read port. It streams each value out on a valid/ready interface together with its index. It is the read-side counterpart of the register file's write port, and is used by the debug/trace path to snapshot x0..x31 without stalling the write-back port. One register is read per READ cycle, then held on the output until it is accepted.

Parameters:
XLEN, 32, data width of register values and the output stream
NREGS, 32, number of architectural registers; index width is clog2(NREGS) = 5

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous reset, active-low
start  in  1  one-cycle request; sampled only in IDLE
first_idx  in  5  first register index, latched on accepted start
last_idx  in  5  last register index (inclusive), latched on accepted start
abort  in  1  cancel the dump in progress
rf_addr  out  5  address to register-file read port (combinational read, data same cycle)
rf_data  in  XLEN  read data from register file
out_valid  out  1  stream word valid
out_ready  in  1  consumer ready
out_data  out  XLEN  register value
out_index  out  5  register index of out_data
out_last  out  1  high with the final word of the range
busy  out  1  high in READ and SEND
done  out  1  one-cycle pulse at end of dump or abort
err  out  1  one-cycle pulse, together with done, when the range is illegal

Behaviour:
- Reset (rst_n low, async): state=IDLE. rf_addr, out_valid, out_data, out_index, out_last, busy, done, err all 0. Internal cur/last pointers are 0.
- States: IDLE, READ, SEND, DONE.
- IDLE:
  - rf_addr=0.
  - start=1 and first_idx<=last_idx: latch cur=first_idx, last=last_idx, go to READ.
  - start=1 and first_idx>last_idx: next cycle done=1, err=1; stay IDLE and emit no stream word.
- READ (1 cycle):
  - rf_addr=cur.
  - At clock edge: out_data<=rf_data, out_index<=cur, out_last<=(cur==last), out_valid<=1; go to SEND.
- SEND:
  - rf_addr holds cur.
  - out_valid, out_data, out_index and out_last stay stable until out_valid&&out_ready.
  - On handshake with out_last=0: out_valid<=0, cur<=cur+1, go to READ.
  - On handshake with out_last=1: out_valid<=0, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Throughput: at most one word per 2 cycles. Latency from start to first out_valid is 2 cycles.
- Snapshot semantics: each value is the register contents combinationally visible in its READ cycle. A register-file write committed before that edge is visible; a later write is not. Index 0 reads whatever the port returns (0 by register-file contract); the block does not special-case it.
- abort in READ or SEND:
  - Next state is DONE; out_valid drops to 0 the following cycle without a handshake.
  - done pulses; err stays 0.
  - abort in IDLE or DONE is ignored.
  - abort has priority over a simultaneous handshake.
- start while busy or in DONE is ignored. No queuing.
- Range first_idx==last_idx yields exactly one word with out_last=1.
- last_idx=31: cur never increments past 31, so there is no wrap-around.
- Reset asserted mid-dump: immediate return to IDLE with all outputs 0. No done pulse.
- busy=1 exactly in READ and SEND.

Test Plan:
- Full dump:
  - Stimulus: preload x1..x31 with 0x1000_0000+i, x5=0xDEAD_BEEF, out_ready=1, start with first=0, last=31.
  - Required: 32 words with indices 0..31 in order; data 0, 0x1000_0001, ..., index 5 = 0xDEAD_BEEF; out_last only on index 31; done one cycle after the last handshake; total 65 cycles from start to done.
- Backpressure:
  - Stimulus: range 3..5, out_ready low for 4 cycles on each word.
  - Required: out_data and out_index stable while stalled; exactly 3 words (3, 4, 5); no duplicates or drops.
- Single and illegal ranges:
  - Stimulus: first=last=7.
  - Required: one word, index 7, out_last=1.
  - Stimulus: first=9, last=2.
  - Required: done=err=1 for one cycle, out_valid never asserted.
- Abort:
  - Stimulus: range 0..31, assert abort in SEND of index 4 while out_ready=1.
  - Required: index 4 is not counted as transferred; out_valid=0 the next cycle; done pulse, err=0; busy low afterwards; a new start is then accepted.
- Reset mid-op:
  - Stimulus: drop rst_n asynchronously during READ of index 10.
  - Required: all outputs 0 immediately, no done pulse; a following start with range 0..1 works normally.
- Snapshot timing:
  - Stimulus: write x6=0xCAFE_F00D during the SEND phase of index 5.
  - Required: index 6 word = 0xCAFE_F00D.
